// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size encodings, FSM states and default address width for the MEM-stage access unit
package mips_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: picks the addressed byte/half lane of a read word and sign- or zero-extends it to 32 bits
module load_formatter
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_size == SZ_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
             i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage req/ack data-memory access with lane formatting and pipeline stall
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise AlignErrM for one cycle.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemSizeM,
  input  logic              MemSignedM,
  input  logic [ADDR_W-1:0] ALUoutM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataMem,
  output logic              StallM,
  output logic              AlignErrM,
  output logic              DMemReq,
  output logic              DMemWe,
  output logic [ADDR_W-1:0] DMemAddr,
  output logic [3:0]        DMemBe,
  output logic [31:0]       DMemWData,
  input  logic [31:0]       DMemRData,
  input  logic              DMemAck
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be, w_be;
  logic [31:0]       r_wdata, w_wdata, r_rdata, w_fmt;
  logic              r_we, r_signed, r_align_err, w_access, w_start, w_mis;
  logic [1:0]        r_size, r_lo;

  assign w_access = MemReadM | MemWriteM;
  assign w_start  = r_state == IDLE && w_access;
`ifdef MEM_ALIGN_TRAP_EN
  assign w_mis = (MemSizeM == SZ_HALF && ALUoutM[0]) || (MemSizeM[1] && ALUoutM[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_be    = MemSizeM == SZ_BYTE ? 4'b0001 << ALUoutM[1:0] :
              MemSizeM == SZ_HALF ? (ALUoutM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wdata = MemSizeM == SZ_BYTE ? {4{WriteDataM[7:0]}} :
              MemSizeM == SZ_HALF ? {2{WriteDataM[15:0]}} : WriteDataM;
  end

  always_comb begin
    w_next = r_state == IDLE ? (w_access ? (w_mis ? DONE : REQ) : IDLE) :
             r_state == REQ  ? (DMemAck ? DONE : REQ) : IDLE;
  end

  load_formatter u_fmt (
    .i_rdata (DMemRData),
    .i_lo    (r_lo),
    .i_size  (r_size),
    .i_signed(r_signed),
    .o_data  (w_fmt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_lo        <= 2'b00;
      r_rdata     <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_align_err <= w_start && w_mis;
      if (w_start && w_mis) r_rdata <= '0;
      if (w_start && !w_mis) begin
        r_addr   <= {ALUoutM[ADDR_W-1:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_we     <= MemWriteM;
        r_size   <= MemSizeM;
        r_signed <= MemSignedM;
        r_lo     <= ALUoutM[1:0];
      end
      if (r_state == REQ && DMemAck) r_rdata <= r_we ? '0 : w_fmt;
    end
  end

  assign StallM      = w_start || r_state == REQ;
  assign DMemReq     = r_state == REQ;
  assign DMemWe      = r_we;
  assign DMemAddr    = r_addr;
  assign DMemBe      = r_be;
  assign DMemWData   = r_wdata;
  assign ReadDataMem = r_rdata;
  assign AlignErrM   = r_align_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized accesses checked against an arithmetic reference model
module tb_mem_access_unit;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        MemReadM = 0, MemWriteM = 0, MemSignedM = 0, DMemAck = 0;
  logic [1:0]  MemSizeM = 0;
  logic [31:0] ALUoutM = 0, WriteDataM = 0, DMemRData = 0;
  logic [31:0] ReadDataMem, DMemAddr, DMemWData;
  logic        StallM, AlignErrM, DMemReq, DMemWe;
  logic [3:0]  DMemBe;
  int          checks = 0, failures = 0;
  logic [31:0] exp_rd = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .MemSignedM(MemSignedM), .ALUoutM(ALUoutM), .WriteDataM(WriteDataM), .ReadDataMem(ReadDataMem),
    .StallM(StallM), .AlignErrM(AlignErrM), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemBe(DMemBe), .DMemWData(DMemWData), .DMemRData(DMemRData), .DMemAck(DMemAck)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 0) return 32'd1 << a[1:0];
    if (sz == 1) return 32'd3 << (a[1] * 2);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a, input logic [31:0] rd);
    int bits = sz == 0 ? 8 : sz == 1 ? 16 : 32;
    int sh = sz == 0 ? int'(a[1:0]) * 8 : sz == 1 ? int'(a[1]) * 16 : 0;
    logic [31:0] mask = bits == 32 ? 32'hFFFF_FFFF : (32'd1 << bits) - 1;
    logic [31:0] v = (rd >> sh) & mask;
    if (sgn && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_TRAP_EN
    return sz == 1 ? a[0] : sz >= 2 ? a[1:0] != 0 : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata, input int waits);
    int stalls = 0;
    @(negedge CLK);
    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sgn; ALUoutM = a; WriteDataM = wd;
    DMemAck = 1'($urandom_range(0, 1)); DMemRData = $urandom;
    #1;
    stalls += int'(StallM);
    check("idle_stall", StallM, 1);
    check("idle_req", DMemReq, 0);
    check("idle_aerr", AlignErrM, 0);
    check("rd_hold", ReadDataMem, exp_rd);
    if (m_mis(sz, a)) begin
      @(negedge CLK);
      MemReadM = 0; MemWriteM = 0; DMemAck = 0;
      #1;
      exp_rd = 0;
      check("trap_aerr", AlignErrM, 1);
      check("trap_req", DMemReq, 0);
      check("trap_stall", StallM, 0);
      check("trap_rd", ReadDataMem, exp_rd);
      check("trap_stall_cnt", stalls, 1);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge CLK);
      DMemAck = i == waits;
      DMemRData = i == waits ? rdata : $urandom;
      #1;
      stalls += int'(StallM);
      check("req", DMemReq, 1);
      check("addr", DMemAddr, a & ~32'd3);
      check("be", {28'd0, DMemBe}, m_be(sz, a));
      check("we", DMemWe, wr);
      if (wr) check("wdata", DMemWData, m_wd(sz, wd));
    end
    @(negedge CLK);
    MemReadM = 0; MemWriteM = 0;
    DMemAck = 1'($urandom_range(0, 1)); DMemRData = $urandom;
    #1;
    exp_rd = wr ? 32'd0 : m_load(sz, sgn, a, rdata);
    check("done_req", DMemReq, 0);
    check("done_stall", StallM, 0);
    check("done_aerr", AlignErrM, 0);
    check("done_rd", ReadDataMem, exp_rd);
    check("stall_cnt", stalls, waits + 2);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    check("rst_req", DMemReq, 0);
    check("rst_we", DMemWe, 0);
    check("rst_addr", DMemAddr, 0);
    check("rst_be", {28'd0, DMemBe}, 0);
    check("rst_wdata", DMemWData, 0);
    check("rst_rd", ReadDataMem, 0);
    check("rst_aerr", AlignErrM, 0);
    check("rst_stall", StallM, 0);
    @(negedge CLK);
    RST = 0;
    access(1, 0, 2'b10, 0, 32'h10, 0, 32'hDEAD_BEEF, 0);
    access(1, 0, 2'b00, 1, 32'h13, 0, 32'h80FF_7F01, 0);
    access(1, 0, 2'b00, 0, 32'h13, 0, 32'h80FF_7F01, 1);
    access(0, 1, 2'b01, 0, 32'h22, 32'h1234, 32'hAAAA_5555, 3);
    access(1, 0, 2'b01, 1, 32'h22, 0, 32'h8001_7FFF, 2);
    access(1, 1, 2'b10, 0, 32'h30, 32'hCAFE_F00D, 32'h1111_2222, 0);
    access(1, 0, 2'b10, 0, 32'h6, 0, 32'h0BAD_F00D, 0);
    access(1, 0, 2'b01, 0, 32'h5, 0, 32'hFEDC_BA98, 1);
    access(1, 0, 2'b00, 1, 32'h11, 0, 32'h0000_8000, 0);
    @(negedge CLK);
    MemReadM = 1; MemSizeM = 2'b10; ALUoutM = 32'h40; DMemAck = 0;
    @(negedge CLK);
    #1;
    check("rstreq_req", DMemReq, 1);
    RST = 1;
    @(negedge CLK);
    RST = 0; MemReadM = 0; DMemAck = 1; DMemRData = 32'h5A5A_5A5A;
    #1;
    exp_rd = 0;
    check("rstreq_req0", DMemReq, 0);
    check("rstreq_stall", StallM, 0);
    check("rstreq_rd", ReadDataMem, exp_rd);
    @(negedge CLK);
    DMemAck = 0;
    #1;
    check("late_ack_req", DMemReq, 0);
    check("late_ack_rd", ReadDataMem, exp_rd);
    for (int n = 0; n < 150; n++) begin
      int op = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        MemReadM = 0; MemWriteM = 0; DMemAck = 1'($urandom_range(0, 1));
        #1;
        check("gap_stall", StallM, 0);
        check("gap_req", DMemReq, 0);
        check("gap_rd", ReadDataMem, exp_rd);
      end
      access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit of the 5-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It takes the load/store controls, address (ALUoutM) and store data of the instruction in MEM, runs a request/acknowledge transaction on the data-memory bus, and produces the byte-aligned, sign- or zero-extended ReadDataMem consumed by MEM/WB. It stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, data-memory byte address width
Ports:
- CLK  in  1  pipeline clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- MemSizeM  in  2  00 byte, 01 half, 10 word (11 treated as word)
- MemSignedM  in  1  1 = sign-extend loads, 0 = zero-extend
- ALUoutM  in  ADDR_W  effective byte address
- WriteDataM  in  32  store data, right-aligned
- ReadDataMem  out  32  formatted load data to MEM/WB
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB
- AlignErrM  out  1  one-cycle misaligned-access flag
- DMemReq  out  1  bus request
- DMemWe  out  1  1 = write
- DMemAddr  out  ADDR_W  word-aligned address (low 2 bits 0)
- DMemBe  out  4  byte enables
- DMemWData  out  32  lane-replicated write data
- DMemRData  in  32  read data, valid with DMemAck
- DMemAck  in  1  one-cycle completion

## Operation
- FSM states IDLE, REQ, DONE. Reset: IDLE; DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData, ReadDataMem, AlignErrM all 0.
- IDLE: if MemReadM|MemWriteM, register address/Be/WData/We/size/sign, go REQ. Otherwise stay.
- REQ: DMemReq=1, bus outputs held constant. On DMemAck go DONE; for reads capture formatted DMemRData into ReadDataMem. No ack: stay, unbounded.
- DONE: DMemReq=0, StallM=0 for exactly one cycle so MEM/WB captures; next state IDLE unconditionally.
- StallM (combinational) = (IDLE & (MemReadM|MemWriteM)) | REQ.
- Byte enables: word 1111; half addr[1] ? 1100 : 0011; byte 0001 << addr[1:0].
- Write data: byte replicated ×4, half replicated ×2, word as is.
- Load format: select lane by addr[1:0], extend per MemSignedM to 32 bits.
- MemReadM and MemWriteM both high: performed as write; ReadDataMem cleared to 0.
- Stores clear ReadDataMem to 0 in DONE.
- DMemAck outside REQ is ignored.
- RST in any state: next cycle IDLE, DMemReq low, ReadDataMem 0; late ack ignored.

## Timing
- Zero-wait memory (ack in first REQ cycle): access presented cycle 0, REQ cycle 1, DONE cycle 2; StallM high cycles 0-1, ReadDataMem valid from cycle 2 and stable until the next capture.
- Each extra wait cycle adds one StallM cycle.
- Back-to-back accesses: new instruction sampled in IDLE after DONE; minimum 3 cycles per access.
- No combinational path from DMemAck or DMemRData to any bus output.

## Configuration
- MEM_ALIGN_TRAP_EN defined: in IDLE, half with addr[0]=1 or word with addr[1:0]≠0 skips REQ, goes straight to DONE with AlignErrM=1 for that cycle, no bus request, ReadDataMem 0; StallM high only in the IDLE cycle.
- Not defined: misalignment not checked; half uses addr[1], word ignores addr[1:0]; AlignErrM tied 0.

## Structure
- Package mips_mem_pkg: MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, ADDR_W default.
- Sub-module load_formatter (combinational): lane select plus sign/zero extension from rdata, addr[1:0], size, signed.

## Test plan
- Word load addr 0x0000_0010, DMemRData 0xDEAD_BEEF, ack in first REQ cycle -> DMemBe 1111, DMemAddr 0x10, StallM 2 cycles, ReadDataMem 0xDEAD_BEEF in DONE.
- Signed byte load addr 0x13, rdata 0x80FF_7F01 -> Be 1000, ReadDataMem 0xFFFF_FF80; unsigned -> 0x0000_0080.
- Half store 0x1234 at addr 0x22, ack after 3 wait cycles -> DMemWe 1, Be 1100, WData 0x1234_1234, StallM 5 cycles, ReadDataMem 0.
- RST asserted in REQ, then ack one cycle later -> IDLE, DMemReq 0, ack ignored, ReadDataMem 0.
- With MEM_ALIGN_TRAP_EN, word load addr 0x6 -> no DMemReq, AlignErrM 1 for one cycle, StallM 1 cycle; without it -> normal access at 0x4.
